// File: rtl/clue_stream_pkg.sv
// Shared definitions for the clue streaming engine: header field layout,
// controller states and the per-clue tag carried alongside ROM data.
package clue_stream_pkg;

  localparam int unsigned DIM_W    = 8;
  localparam int unsigned ROWS_LSB = 0;
  localparam int unsigned COLS_LSB = 8;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    HDR_WAIT,
    STREAM,
    FINISH
  } state_t;

  typedef struct packed {
    logic             is_col;
    logic [DIM_W-1:0] index;
  } clue_tag_t;

  localparam int unsigned TAG_W = $bits(clue_tag_t);

endpackage

// File: rtl/clue_skid_fifo.sv
// Small synchronous FIFO with occupancy count; head entry reads as zero when empty.
module clue_skid_fifo #(
  parameter  int unsigned WIDTH = 29,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_in,
  input  logic             reset_n_in,
  input  logic             push_in,
  input  logic [WIDTH-1:0] push_data_in,
  input  logic             pop_in,
  output logic [WIDTH-1:0] pop_data_out,
  output logic [CNT_W-1:0] count_out
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_in) begin
    if (push_in) mem[wr_ptr] <= push_data_in;
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_out <= '0;
    end else begin
      if (push_in) wr_ptr <= ptr_next(wr_ptr);
      if (pop_in)  rd_ptr <= ptr_next(rd_ptr);
      case ({push_in, pop_in})
        2'b10:   count_out <= count_out + CNT_W'(1);
        2'b01:   count_out <= count_out - CNT_W'(1);
        default: count_out <= count_out;
      endcase
    end
  end

  assign pop_data_out = (count_out != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/clue_stream_engine.sv
// Fetches one puzzle's header and row/column clues from a synchronous ROM and
// streams them over valid/ready, with credit flow control against a skid FIFO.
module clue_stream_engine
  import clue_stream_pkg::*;
#(
  parameter  int unsigned CLUE_W      = 20,
  parameter  int unsigned NUM_PUZZLES = 4,
  parameter  int unsigned ROWS_MAX    = 20,
  parameter  int unsigned COLS_MAX    = 20,
  parameter  int unsigned READ_LAT    = 2,
  localparam int unsigned SEL_W       = (NUM_PUZZLES > 1) ? $clog2(NUM_PUZZLES) : 1,
  localparam int unsigned ADDR_W      = $clog2(NUM_PUZZLES * (1 + ROWS_MAX + COLS_MAX))
) (
  input  logic              clk_in,
  input  logic              reset_n_in,
  input  logic              start_in,
  input  logic [SEL_W-1:0]  puzzle_sel_in,
  output logic              rom_en_out,
  output logic [ADDR_W-1:0] rom_addr_out,
  input  logic [CLUE_W-1:0] rom_data_in,
  output logic [CLUE_W-1:0] clue_out,
  output logic              clue_is_col_out,
  output logic [7:0]        clue_index_out,
  output logic              clue_valid_out,
  input  logic              clue_ready_in,
  output logic              busy_out,
  output logic              done_out,
  output logic              err_out
);

  localparam int unsigned STRIDE     = 1 + ROWS_MAX + COLS_MAX;
  localparam int unsigned FIFO_DEPTH = READ_LAT + 2;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ENTRY_W    = TAG_W + CLUE_W;

  state_t                    state;
  logic [ADDR_W-1:0]         base_q;
  logic [DIM_W-1:0]          rows_q;
  logic [DIM_W-1:0]          cols_q;
  logic [2:0]                wait_cnt;
  logic [DIM_W:0]            issue_cnt;
  logic [DIM_W:0]            xfer_cnt;
  logic [READ_LAT:0]         sr_vld;
  clue_tag_t [READ_LAT:0]    sr_tag;

  logic [DIM_W-1:0]          hdr_rows;
  logic [DIM_W-1:0]          hdr_cols;
  logic                      hdr_ok;
  logic [DIM_W:0]            total;
  logic [DIM_W:0]            col_cnt;
  clue_tag_t                 iss_tag;
  logic [ADDR_W-1:0]         iss_addr;
  logic [ADDR_W-1:0]         sel_base;
  int unsigned               inflight;
  logic                      pop;
  logic                      credit_ok;
  logic [CNT_W-1:0]          fifo_count;
  logic [ENTRY_W-1:0]        fifo_out;
  clue_tag_t                 out_tag;

  assign hdr_rows = rom_data_in[ROWS_LSB +: DIM_W];
  assign hdr_cols = rom_data_in[COLS_LSB +: DIM_W];
  assign hdr_ok   = (hdr_rows != '0) && (32'(hdr_rows) <= ROWS_MAX) &&
                    (hdr_cols != '0) && (32'(hdr_cols) <= COLS_MAX);
  assign total    = {1'b0, rows_q} + {1'b0, cols_q};
  assign col_cnt  = issue_cnt - {1'b0, rows_q};
  assign sel_base = ADDR_W'(32'(puzzle_sel_in) * STRIDE);

  always_comb begin
    iss_tag  = '0;
    iss_addr = '0;
    if (issue_cnt < {1'b0, rows_q}) begin
      iss_tag.index = issue_cnt[DIM_W-1:0];
      iss_addr      = base_q + ADDR_W'(1) + ADDR_W'(issue_cnt);
    end else begin
      iss_tag.is_col = 1'b1;
      iss_tag.index  = col_cnt[DIM_W-1:0];
      iss_addr       = base_q + ADDR_W'(1 + ROWS_MAX) + ADDR_W'(col_cnt);
    end
  end

  always_comb begin
    inflight = 0;
    for (int unsigned i = 0; i <= READ_LAT; i++) inflight += 32'(sr_vld[i]);
  end

  // An entry popped this cycle frees its slot in time for a read issued now.
  assign pop       = clue_valid_out & clue_ready_in;
  assign credit_ok = (32'(fifo_count) + inflight) < (FIFO_DEPTH + 32'(pop));

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      state        <= IDLE;
      busy_out     <= 1'b0;
      done_out     <= 1'b0;
      err_out      <= 1'b0;
      rom_en_out   <= 1'b0;
      rom_addr_out <= '0;
      base_q       <= '0;
      rows_q       <= '0;
      cols_q       <= '0;
      wait_cnt     <= '0;
      issue_cnt    <= '0;
      xfer_cnt     <= '0;
      sr_vld       <= '0;
      sr_tag       <= '0;
    end else begin
      sr_vld     <= {sr_vld[READ_LAT-1:0], 1'b0};
      sr_tag     <= {sr_tag[READ_LAT-1:0], clue_tag_t'('0)};
      rom_en_out <= 1'b0;
      done_out   <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            busy_out <= 1'b1;
            err_out  <= 1'b0;
            if (32'(puzzle_sel_in) >= NUM_PUZZLES) begin
              err_out  <= 1'b1;
              done_out <= 1'b1;
              state    <= FINISH;
            end else begin
              base_q       <= sel_base;
              rom_addr_out <= sel_base;
              rom_en_out   <= 1'b1;
              state        <= HDR;
            end
          end
        end
        HDR: begin
          wait_cnt <= 3'(READ_LAT - 1);
          state    <= HDR_WAIT;
        end
        HDR_WAIT: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 3'd1;
          end else begin
            rows_q    <= hdr_rows;
            cols_q    <= hdr_cols;
            issue_cnt <= (DIM_W + 1)'(1);
            xfer_cnt  <= '0;
            if (hdr_ok) begin
              // Row 0 is issued here so the first data read follows the header directly.
              rom_en_out   <= 1'b1;
              rom_addr_out <= base_q + ADDR_W'(1);
              sr_vld[0]    <= 1'b1;
              sr_tag[0]    <= clue_tag_t'('0);
              state        <= STREAM;
            end else begin
              err_out  <= 1'b1;
              done_out <= 1'b1;
              state    <= FINISH;
            end
          end
        end
        STREAM: begin
          if ((issue_cnt < total) && credit_ok) begin
            rom_en_out   <= 1'b1;
            rom_addr_out <= iss_addr;
            sr_vld[0]    <= 1'b1;
            sr_tag[0]    <= iss_tag;
            issue_cnt    <= issue_cnt + (DIM_W + 1)'(1);
          end
          if (pop) begin
            xfer_cnt <= xfer_cnt + (DIM_W + 1)'(1);
            if (xfer_cnt == total - (DIM_W + 1)'(1)) begin
              done_out <= 1'b1;
              state    <= FINISH;
            end
          end
        end
        FINISH: begin
          busy_out <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  clue_skid_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in       (clk_in),
    .reset_n_in   (reset_n_in),
    .push_in      (sr_vld[READ_LAT]),
    .push_data_in ({sr_tag[READ_LAT], rom_data_in}),
    .pop_in       (pop),
    .pop_data_out (fifo_out),
    .count_out    (fifo_count)
  );

  assign out_tag         = clue_tag_t'(fifo_out[CLUE_W +: TAG_W]);
  assign clue_out        = fifo_out[CLUE_W-1:0];
  assign clue_is_col_out = out_tag.is_col;
  assign clue_index_out  = out_tag.index;
  assign clue_valid_out  = (fifo_count != '0);

endmodule

// File: tb/tb_clue_stream_engine.sv
// Directed bench for clue_stream_engine with a behavioural 2-cycle ROM.
module tb_clue_stream_engine;

  localparam int unsigned CLUE_W = 20;
  localparam int unsigned NP     = 3;
  localparam int unsigned STRIDE = 41;
  localparam int unsigned DEPTH  = 4;

  logic        clk_in = 1'b0;
  logic        reset_n_in;
  logic        start_in;
  logic [1:0]  puzzle_sel_in;
  logic        rom_en_out;
  logic [6:0]  rom_addr_out;
  logic [19:0] rom_data_in;
  logic [19:0] clue_out;
  logic        clue_is_col_out;
  logic [7:0]  clue_index_out;
  logic        clue_valid_out;
  logic        clue_ready_in;
  logic        busy_out;
  logic        done_out;
  logic        err_out;

  always #5 clk_in = ~clk_in;

  clue_stream_engine #(
    .CLUE_W      (CLUE_W),
    .NUM_PUZZLES (NP),
    .ROWS_MAX    (20),
    .COLS_MAX    (20),
    .READ_LAT    (2)
  ) dut (
    .clk_in          (clk_in),
    .reset_n_in      (reset_n_in),
    .start_in        (start_in),
    .puzzle_sel_in   (puzzle_sel_in),
    .rom_en_out      (rom_en_out),
    .rom_addr_out    (rom_addr_out),
    .rom_data_in     (rom_data_in),
    .clue_out        (clue_out),
    .clue_is_col_out (clue_is_col_out),
    .clue_index_out  (clue_index_out),
    .clue_valid_out  (clue_valid_out),
    .clue_ready_in   (clue_ready_in),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .err_out         (err_out)
  );

  logic [19:0] rom [NP*STRIDE];
  logic [19:0] rom_p1;
  always @(posedge clk_in) begin
    rom_p1      <= rom_en_out ? rom[rom_addr_out] : 'x;
    rom_data_in <= rom_p1;
  end

  function automatic logic [19:0] clue_word(input int a);
    logic [7:0] a8;
    a8 = 8'(a);
    return {4'hC, a8, a8 ^ 8'h5A};
  endfunction

  function automatic int exp_addr(input int sel, input int k, input int rows);
    return (k < rows) ? sel * STRIDE + 1 + k : sel * STRIDE + 21 + (k - rows);
  endfunction

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Protocol watchers: outstanding reads bounded by FIFO depth; payload held while stalled.
  int          outstanding = 0;
  logic        rn_last = 1'b0;
  logic        prev_stall = 1'b0;
  logic [28:0] prev_pay;
  always @(negedge clk_in) begin
    if (!rn_last) outstanding = 0;
    else if (prev_stall) begin
      tests++;
      assert (clue_valid_out && {clue_is_col_out, clue_index_out, clue_out} === prev_pay) else begin
        fails++;
        $error("FAIL stall_hold: observed %0b/%0h expected 1/%0h", clue_valid_out,
               {clue_is_col_out, clue_index_out, clue_out}, prev_pay);
      end
    end
    if (rom_en_out && (32'(rom_addr_out) % STRIDE) != 0) begin
      outstanding++;
      tests++;
      assert (outstanding <= DEPTH) else begin
        fails++;
        $error("FAIL credit: observed %0d outstanding expected <= %0d", outstanding, DEPTH);
      end
    end
    if (clue_valid_out && clue_ready_in) outstanding--;
    prev_stall = clue_valid_out && !clue_ready_in && reset_n_in;
    prev_pay   = {clue_is_col_out, clue_index_out, clue_out};
    rn_last    = reset_n_in;
  end

  int          n_xf, first_valid, done_cyc, done_cnt, en_cnt, valid_cnt;
  int          xf_cyc [64];
  logic [28:0] xf_pay [64];
  int          en_cyc [64];
  logic [6:0]  en_addr [64];
  logic        busy_c1, err_c1, busy_at_done, err_at_done, busy_after, err_after;

  task automatic do_run(input logic [1:0] sel, input int mode, input bit poke, input int stop_after);
    n_xf = 0; first_valid = -1; done_cyc = -1; done_cnt = 0; en_cnt = 0; valid_cnt = 0;
    busy_c1 = 1'bx; err_c1 = 1'bx; busy_at_done = 1'bx; err_at_done = 1'bx;
    busy_after = 1'bx; err_after = 1'bx;
    @(posedge clk_in); #1;
    start_in = 1'b1; puzzle_sel_in = sel; clue_ready_in = 1'b1;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(posedge clk_in); #1;
      start_in      = poke && (cyc == 5 || cyc == 10);
      puzzle_sel_in = start_in ? 2'd0 : sel;
      clue_ready_in = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk_in);
      if (cyc == 1) begin busy_c1 = busy_out; err_c1 = err_out; end
      if (rom_en_out && en_cnt < 64) begin
        en_cyc[en_cnt] = cyc; en_addr[en_cnt] = rom_addr_out; en_cnt++;
      end
      if (clue_valid_out) begin
        if (first_valid < 0) first_valid = cyc;
        valid_cnt++;
      end
      if (clue_valid_out && clue_ready_in && n_xf < 64) begin
        xf_cyc[n_xf] = cyc;
        xf_pay[n_xf] = {clue_is_col_out, clue_index_out, clue_out};
        n_xf++;
      end
      if (done_out) begin
        done_cnt++; done_cyc = cyc; busy_at_done = busy_out; err_at_done = err_out;
      end
      if (stop_after > 0 && n_xf >= stop_after) break;
      if (done_cyc > 0 && cyc == done_cyc + 1) begin
        busy_after = busy_out; err_after = err_out;
        break;
      end
    end
    start_in = 1'b0;
  endtask

  task automatic chk_stream(input string tag, input int nexp);
    logic [28:0] e;
    chk({tag, "_count"}, n_xf, nexp);
    for (int k = 0; k < nexp && k < n_xf; k++) begin
      e = {(k >= 5), 8'((k < 5) ? k : k - 5), clue_word(exp_addr(2, k, 5))};
      chk($sformatf("%s_clue%0d", tag, k), xf_pay[k], e);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {busy_out, done_out, err_out, clue_valid_out, rom_en_out, clue_is_col_out}, 0);
    chk({tag, "_addr"}, rom_addr_out, 0);
    chk({tag, "_clue"}, clue_out, 0);
    chk({tag, "_idx"}, clue_index_out, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n_in = 1'b0; start_in = 1'b0; puzzle_sel_in = '0; clue_ready_in = 1'b0;
    for (int a = 0; a < NP * STRIDE; a++) rom[a] = clue_word(a);
    rom[0]  = {4'hF, 8'd7, 8'd0};
    rom[41] = {4'hF, 8'd21, 8'd3};
    rom[82] = {4'hF, 8'd7, 8'd5};

    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk_zero("reset");
    @(posedge clk_in); #1 reset_n_in = 1'b1;

    do_run(2'd2, 0, 1'b0, 0);
    chk("A_hdr_cyc", en_cyc[0], 1);
    chk("A_hdr_addr", en_addr[0], 82);
    chk("A_busy_c1", busy_c1, 1);
    chk("A_row0_cyc", en_cyc[1], 4);
    chk("A_row0_addr", en_addr[1], 83);
    chk("A_col0_addr", en_addr[6], 103);
    chk("A_reads", en_cnt, 13);
    chk("A_first_valid", first_valid, 7);
    chk_stream("A", 12);
    chk("A_last_xf_cyc", xf_cyc[11], 18);
    chk("A_done_cyc", done_cyc, 19);
    chk("A_done_cnt", done_cnt, 1);
    chk("A_busy_done", busy_at_done, 1);
    chk("A_busy_after", busy_after, 0);
    chk("A_err", err_at_done, 0);

    do_run(2'd2, 1, 1'b0, 0);
    chk_stream("B", 12);
    chk("B_done_cyc", done_cyc, xf_cyc[11] + 1);
    chk("B_done_cnt", done_cnt, 1);

    do_run(2'd2, 0, 1'b1, 0);
    chk_stream("C", 12);
    chk("C_done_cyc", done_cyc, 19);
    chk("C_err", err_at_done, 0);

    do_run(2'd0, 0, 1'b0, 0);
    chk("R0_done_cyc", done_cyc, 4);
    chk("R0_err", {err_at_done, err_after}, 2'b11);
    chk("R0_valids", valid_cnt, 0);
    chk("R0_busy_after", busy_after, 0);
    chk("R0_reads", en_cnt, 1);

    do_run(2'd1, 0, 1'b0, 0);
    chk("C21_done_cyc", done_cyc, 4);
    chk("C21_err", err_at_done, 1);
    chk("C21_valids", valid_cnt, 0);

    do_run(2'd3, 0, 1'b0, 0);
    chk("SEL3_done_cyc", done_cyc, 1);
    chk("SEL3_err", err_c1, 1);
    chk("SEL3_reads", en_cnt, 0);
    chk("SEL3_busy_after", busy_after, 0);

    do_run(2'd2, 0, 1'b0, 0);
    chk("CLR_err_c1", err_c1, 0);
    chk_stream("CLR", 12);
    chk("CLR_err_done", err_at_done, 0);

    do_run(2'd2, 0, 1'b0, 4);
    chk("ABT_xf", n_xf, 4);
    @(posedge clk_in); #1 reset_n_in = 1'b0;
    @(negedge clk_in);
    @(posedge clk_in); #1;
    @(negedge clk_in);
    chk_zero("abort");
    @(posedge clk_in); #1 reset_n_in = 1'b1;

    do_run(2'd2, 0, 1'b0, 0);
    chk_stream("RST", 12);
    chk("RST_done_cyc", done_cyc, 19);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
